mem_bus_responder: RTL and testbench

- Lower-level memory agent on the common snoop bus of the 4-core MESI system.
- Answers cache-initiated BusRd/BusRdX line fills and Mem_wr write-backs.
- On a read: waits a fixed latency, requests the bus from the arbiter (Mem_snoop_req/Mem_snoop_gnt), then drives Data_Bus_Com with Data_in_Bus.
- Drops a read if a peer cache supplies the data first (Mem_oprn_abort).

---
 rtl/mem_bus_responder_pkg.sv | 23 ++
 rtl/mem_bus_responder_if.sv | 29 ++
 rtl/mem_bus_responder_store.sv | 39 +++
 rtl/mem_bus_responder.sv | 129 ++++++++++++
 tb/tb_mem_bus_responder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared types and constants for the memory-side responder on the MESI snoop bus.
// Holds the FSM state encoding, the power-up tag and the latency counter sizing.
package mem_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      REQ_BUS,
      DRIVE,
      WRITE,
      WR_DONE
   } mem_state_t;

   localparam logic [31:0] INIT_TAG = 32'hA000_0000;

   // Counter must hold the larger of the two latencies.
   function automatic int cnt_width(input int rd_lat, input int wr_lat);
      int m;
      m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Common snoop bus signals seen by the memory responder.
// The slave modport is the memory side; master is the cache/arbiter side.
interface mem_bus_responder_if #(
   parameter int ADDRESSSIZE = 32
);
   logic                   BusRd;
   logic                   BusRdX;
   logic                   Mem_wr;
   logic                   Mem_oprn_abort;
   logic [ADDRESSSIZE-1:0] Address_Com;
   logic [ADDRESSSIZE-1:0] Data_Bus_Com_in;
   logic                   Mem_snoop_gnt;
   logic                   Mem_snoop_req;
   logic [ADDRESSSIZE-1:0] Data_Bus_Com_out;
   logic                   Data_Bus_Com_oe;
   logic                   Data_in_Bus;
   logic                   Mem_write_done;

   modport slave (
      input  BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Address_Com, Data_Bus_Com_in, Mem_snoop_gnt,
      output Mem_snoop_req, Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_write_done
   );

   modport master (
      output BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Address_Com, Data_Bus_Com_in, Mem_snoop_gnt,
      input  Mem_snoop_req, Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_write_done
   );

endinterface

// File: rtl/mem_bus_responder_store.sv
// Backing store: one word per index, synchronous write, combinational read.
// Contents survive reset; each word powers up as INIT_TAG | index.
module mem_store
   import mem_bus_pkg::*;
#(
   parameter int IDX_W = 8,
   parameter int W     = 32
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [W-1:0]     wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [W-1:0]     rd_data
);

   localparam int DEPTH = 1 << IDX_W;

   logic [W-1:0] word_rd [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic [W-1:0] word_q = W'(INIT_TAG | i);
      logic [W-1:0] word_d;

      always_comb begin
         word_d = word_q;
         if (we && (wr_idx == IDX_W'(i))) word_d = wr_data;
      end

      always_ff @(posedge clk) begin
         word_q <= word_d;
      end

      assign word_rd[i] = word_q;
   end

   assign rd_data = word_rd[rd_idx];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory agent on the 4-core snoop bus: serves line fills after a fixed latency
// plus bus arbitration, and commits write-backs with a done handshake.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int ADDRESSSIZE = 32,
   parameter int MEM_IDX_W   = 8,
   parameter int RD_LATENCY  = 4,
   parameter int WR_LATENCY  = 2
) (
   input logic               clk,
   input logic               rst_n,
   mem_bus_responder_if.slave bus
);

   localparam int CNT_W = cnt_width(RD_LATENCY, WR_LATENCY);

   mem_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [MEM_IDX_W-1:0]   idx_q, idx_d;
   logic                   req_q, req_d;
   logic                   oe_q, oe_d;
   logic                   din_q, din_d;
   logic                   done_q, done_d;
   logic [ADDRESSSIZE-1:0] dout_q, dout_d;

   logic [MEM_IDX_W-1:0]   addr_idx;
   logic [ADDRESSSIZE-1:0] rd_data;
   logic                   rd_any;
   logic                   mem_we;
   logic                   unused_addr_bits;

   // Word addressing; upper bits alias onto the same backing word.
   assign addr_idx         = bus.Address_Com[MEM_IDX_W+1:2];
   assign unused_addr_bits = ^{bus.Address_Com[ADDRESSSIZE-1:MEM_IDX_W+2], bus.Address_Com[1:0]};
   assign rd_any           = bus.BusRd | bus.BusRdX;
   // The write lands on the capture edge so any later read sees it.
   assign mem_we           = (state_q == IDLE) && bus.Mem_wr;

   mem_store #(
      .IDX_W (MEM_IDX_W),
      .W     (ADDRESSSIZE)
   ) u_store (
      .clk     (clk),
      .we      (mem_we),
      .wr_idx  (addr_idx),
      .wr_data (bus.Data_Bus_Com_in),
      .rd_idx  (idx_q),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         req_q   <= 1'b0;
         oe_q    <= 1'b0;
         din_q   <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         req_q   <= req_d;
         oe_q    <= oe_d;
         din_q   <= din_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.Mem_wr) begin
               state_d = WRITE;
               idx_d   = addr_idx;
               cnt_d   = CNT_W'(WR_LATENCY);
            end else if (rd_any) begin
               state_d = RD_WAIT;
               idx_d   = addr_idx;
               cnt_d   = CNT_W'(RD_LATENCY);
            end
         end
         RD_WAIT: begin
            if (bus.Mem_oprn_abort || !rd_any) state_d = IDLE;
            else if (cnt_q == '0)              state_d = REQ_BUS;
            else                               cnt_d   = cnt_q - CNT_W'(1);
         end
         REQ_BUS: begin
            // A peer supplying the line wins over a coincident grant.
            if (bus.Mem_oprn_abort || !rd_any) state_d = IDLE;
            else if (bus.Mem_snoop_gnt)        state_d = DRIVE;
         end
         DRIVE: begin
            if (!rd_any) state_d = IDLE;
         end
         WRITE: begin
            if (cnt_q == '0) state_d = WR_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         WR_DONE: begin
            if (!bus.Mem_wr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered: each reflects the state being entered.
   always_comb begin
      req_d  = (state_d == REQ_BUS);
      oe_d   = (state_d == DRIVE);
      din_d  = (state_d == DRIVE);
      done_d = (state_d == WR_DONE);
      dout_d = (state_d == DRIVE) ? rd_data : '0;
   end

   assign bus.Mem_snoop_req    = req_q;
   assign bus.Data_Bus_Com_oe  = oe_q;
   assign bus.Data_in_Bus      = din_q;
   assign bus.Mem_write_done   = done_q;
   assign bus.Data_Bus_Com_out = dout_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized scenario bench for mem_bus_responder against a word-array reference
// model with latency expectations derived from the read/write timing rules.
module tb_mem_bus_responder;

   localparam int RD_LAT = 4;
   localparam int WR_LAT = 2;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   logic [31:0] model_mem [256];

   mem_bus_responder_if #(.ADDRESSSIZE(32)) bus ();

   mem_bus_responder #(
      .ADDRESSSIZE (32),
      .MEM_IDX_W   (8),
      .RD_LATENCY  (RD_LAT),
      .WR_LATENCY  (WR_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] addr, input bit use_x, input int gdly, input int hold);
      logic [31:0] exp;
      logic        exp_req;
      exp = model_mem[addr[9:2]];
      bus.BusRd         = !use_x;
      bus.BusRdX        = use_x;
      bus.Address_Com   = addr;
      bus.Mem_snoop_gnt = (gdly == 0);
      step();
      for (int k = 1; k <= RD_LAT + 1; k++) begin
         step();
         exp_req = (k == RD_LAT + 1);
         n_cmp++;
         if (bus.Mem_snoop_req !== exp_req) begin
            n_fail++;
            $display("FAIL rd_req_latency k=%0d: got %b want %b", k, bus.Mem_snoop_req, exp_req);
         end
         n_cmp++;
         if (bus.Data_in_Bus !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_early_din k=%0d: got %b want 0", k, bus.Data_in_Bus);
         end
      end
      for (int d = 0; d < gdly; d++) begin
         step();
         n_cmp++;
         if (bus.Mem_snoop_req !== 1'b1 || bus.Data_Bus_Com_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wait_grant d=%0d: got req=%b oe=%b want req=1 oe=0", d, bus.Mem_snoop_req, bus.Data_Bus_Com_oe);
         end
      end
      bus.Mem_snoop_gnt = 1'b1;
      step();
      n_cmp++;
      if (bus.Data_in_Bus !== 1'b1 || bus.Data_Bus_Com_oe !== 1'b1 || bus.Mem_snoop_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_drive_ctl: got din=%b oe=%b req=%b want 1 1 0", bus.Data_in_Bus, bus.Data_Bus_Com_oe, bus.Mem_snoop_req);
      end
      n_cmp++;
      if (bus.Data_Bus_Com_out !== exp) begin
         n_fail++;
         $display("FAIL rd_data addr=%h: got %h want %h", addr, bus.Data_Bus_Com_out, exp);
      end
      bus.Mem_snoop_gnt = 1'b0;
      for (int h = 0; h < hold; h++) begin
         bus.Address_Com = $urandom;
         step();
         n_cmp++;
         if (bus.Data_Bus_Com_oe !== 1'b1 || bus.Data_Bus_Com_out !== exp) begin
            n_fail++;
            $display("FAIL rd_hold h=%0d: got oe=%b data=%h want oe=1 data=%h", h, bus.Data_Bus_Com_oe, bus.Data_Bus_Com_out, exp);
         end
      end
      bus.BusRd  = 1'b0;
      bus.BusRdX = 1'b0;
      step();
      n_cmp++;
      if (bus.Data_Bus_Com_oe !== 1'b0 || bus.Data_in_Bus !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_release: got oe=%b din=%b want 0 0", bus.Data_Bus_Com_oe, bus.Data_in_Bus);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int hold);
      logic exp_done;
      bus.Mem_wr          = 1'b1;
      bus.Address_Com     = addr;
      bus.Data_Bus_Com_in = data;
      step();
      model_mem[addr[9:2]] = data;
      bus.Data_Bus_Com_in = $urandom;
      for (int k = 1; k <= WR_LAT + 1; k++) begin
         step();
         exp_done = (k == WR_LAT + 1);
         n_cmp++;
         if (bus.Mem_write_done !== exp_done || bus.Mem_snoop_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_latency k=%0d: got done=%b req=%b want done=%b req=0", k, bus.Mem_write_done, bus.Mem_snoop_req, exp_done);
         end
      end
      for (int h = 0; h < hold; h++) begin
         step();
         n_cmp++;
         if (bus.Mem_write_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_done_hold h=%0d: got %b want 1", h, bus.Mem_write_done);
         end
      end
      bus.Mem_wr = 1'b0;
      step();
      n_cmp++;
      if (bus.Mem_write_done !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_done_release: got %b want 0", bus.Mem_write_done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.Mem_snoop_req, bus.Data_Bus_Com_oe, bus.Data_in_Bus, bus.Mem_write_done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctl: got req/oe/din/done=%b want 0000",
                  {bus.Mem_snoop_req, bus.Data_Bus_Com_oe, bus.Data_in_Bus, bus.Mem_write_done});
      end
      n_cmp++;
      if (bus.Data_Bus_Com_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0", bus.Data_Bus_Com_out);
      end
      #3 rst_n = 1'b1;
      step();
   endtask

   task automatic test_read_immediate();
      do_read(32'h0000_0010, 1'b0, 0, 2);
   endtask

   task automatic test_write_read();
      do_write(32'h0000_0020, 32'hDEAD_BEEF, 2);
      do_read(32'h0000_0020, 1'b1, 0, 1);
   endtask

   task automatic test_abort_rd_wait();
      bus.BusRd         = 1'b1;
      bus.Address_Com   = 32'h0000_0030;
      bus.Mem_snoop_gnt = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (i == 3) bus.Mem_oprn_abort = 1'b1;
         if (i == 4) bus.Mem_oprn_abort = 1'b0;
         if (i == 7) bus.BusRd = 1'b0;
         step();
         n_cmp++;
         if (bus.Mem_snoop_req !== 1'b0 || bus.Data_in_Bus !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rd_wait i=%0d: got req=%b din=%b want 0 0", i, bus.Mem_snoop_req, bus.Data_in_Bus);
         end
      end
      bus.Mem_snoop_gnt = 1'b0;
   endtask

   task automatic test_abort_req_bus();
      bus.BusRd         = 1'b1;
      bus.Address_Com   = 32'h0000_0034;
      bus.Mem_snoop_gnt = 1'b0;
      step();
      repeat (RD_LAT + 1) step();
      n_cmp++;
      if (bus.Mem_snoop_req !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_req_pre: got req=%b want 1", bus.Mem_snoop_req);
      end
      bus.Mem_oprn_abort = 1'b1;
      step();
      bus.Mem_oprn_abort = 1'b0;
      bus.BusRd          = 1'b0;
      n_cmp++;
      if (bus.Mem_snoop_req !== 1'b0 || bus.Data_Bus_Com_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_req_bus: got req=%b oe=%b want 0 0", bus.Mem_snoop_req, bus.Data_Bus_Com_oe);
      end
      step();
   endtask

   task automatic test_delayed_grant();
      do_read(32'h0000_0048, 1'b0, 6, 1);
   endtask

   task automatic test_simultaneous();
      bus.BusRd = 1'b1;
      do_write(32'h0000_0050, 32'h1234_5678, 1);
      do_read(32'h0000_0050, 1'b0, 0, 0);
   endtask

   task automatic test_reset_mid_drive();
      logic [31:0] d;
      d = $urandom;
      do_write(32'h0000_0044, d, 0);
      bus.BusRd         = 1'b1;
      bus.Address_Com   = 32'h0000_0044;
      bus.Mem_snoop_gnt = 1'b1;
      step();
      repeat (RD_LAT + 2) step();
      n_cmp++;
      if (bus.Data_Bus_Com_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_drive_pre: got oe=%b want 1", bus.Data_Bus_Com_oe);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.Data_Bus_Com_oe, bus.Data_in_Bus, bus.Mem_snoop_req} !== 3'b000 || bus.Data_Bus_Com_out !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_drive_async: got oe/din/req=%b data=%h want 000 0",
                  {bus.Data_Bus_Com_oe, bus.Data_in_Bus, bus.Mem_snoop_req}, bus.Data_Bus_Com_out);
      end
      bus.BusRd         = 1'b0;
      bus.Mem_snoop_gnt = 1'b0;
      #4 rst_n = 1'b1;
      step();
      do_read(32'h0000_0044, 1'b0, 1, 0);
      do_read(32'h0000_0020, 1'b1, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] addr;
      for (int it = 0; it < 24; it++) begin
         addr = {$urandom_range(0, 32'h3F_FFFF), 4'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         addr[31:10] = 22'($urandom);
         if ($urandom_range(0, 1) == 0)
            do_write(addr, $urandom, $urandom_range(0, 2));
         else
            do_read(addr, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      for (int i = 0; i < 256; i++) model_mem[i] = 32'hA000_0000 | 32'(i);
      rst_n               = 1'b0;
      bus.BusRd           = 1'b0;
      bus.BusRdX          = 1'b0;
      bus.Mem_wr          = 1'b0;
      bus.Mem_oprn_abort  = 1'b0;
      bus.Address_Com     = 32'h0;
      bus.Data_Bus_Com_in = 32'h0;
      bus.Mem_snoop_gnt   = 1'b0;

      test_reset();
      test_read_immediate();
      test_write_read();
      test_abort_rd_wait();
      test_abort_req_bus();
      test_delayed_grant();
      test_simultaneous();
      test_reset_mid_drive();
      test_random();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
